// File: rtl/datapath_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle datapath controller (states, ALU codes,
// opcode/funct encodings, writeback source codes, instruction field layout).
package datapath_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_EXE  = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_ADD  = 3'b100,
    ALU_SUB  = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_SLLV = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLLV = 6'b000100;

  localparam logic [1:0] WDS_ALU  = 2'b00;
  localparam logic [1:0] WDS_RAM  = 2'b01;
  localparam logic [1:0] WDS_IDLE = 2'b11;

endpackage

// File: rtl/datapath_ctrl_fsm_decode.sv
// Combinational instruction decoder: IR -> ALU function and instruction class.
module ctrl_instr_decode
  import datapath_ctrl_fsm_pkg::*;
(
  input  instr_t  ir,
  output alu_op_t alu_op,
  output logic    is_lw,
  output logic    is_sw,
  output logic    is_illegal
);

  // Register fields are consumed by the controller, not the decoder.
  logic unused_fields;
  assign unused_fields = ^{ir.rs, ir.rt, ir.rd, ir.shamt};

  always_comb begin
    alu_op     = ALU_AND;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_illegal = 1'b0;
    case (ir.op)
      OP_RTYPE: begin
        case (ir.funct)
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLLV: alu_op = ALU_SLLV;
          default: is_illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        alu_op = ALU_ADD;
        is_lw  = 1'b1;
      end
      OP_SW: begin
        alu_op = ALU_ADD;
        is_sw  = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl_fsm.sv
// Multi-cycle controller sequencing R-type/LW/SW through DEC/EXE/MEM/WB.
// Optional sticky ALU flags are enabled by defining FLAG_STICKY_EN.
module datapath_ctrl_fsm
  import datapath_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             ZF,
  input  logic             OF,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [2:0]       ALU_OP,
  output logic             Write_Reg,
  output logic             Mem_Write,
  output logic [1:0]       wr_data_s,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             zf_sticky,
  output logic             of_sticky,
  input  logic             clr_flags
);

  state_t          state_reg, state_next;
  instr_t          ir_reg;
  logic [CNT_W-1:0] cnt_reg;
  alu_op_t         dec_alu_op;
  logic            dec_is_lw, dec_is_sw, dec_is_illegal;
  logic            accept;

  ctrl_instr_decode u_decode (
    .ir         (ir_reg),
    .alu_op     (dec_alu_op),
    .is_lw      (dec_is_lw),
    .is_sw      (dec_is_sw),
    .is_illegal (dec_is_illegal)
  );

  assign accept      = instr_valid && (state_reg == ST_IDLE);
  assign retired_cnt = cnt_reg;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      ir_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) ir_reg <= instr;
      if (retire) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (instr_valid) state_next = ST_DEC;
      ST_DEC:  state_next = dec_is_illegal ? ST_IDLE : ST_EXE;
      ST_EXE:  state_next = (dec_is_lw || dec_is_sw) ? ST_MEM : ST_WB;
      ST_MEM:  state_next = dec_is_lw ? ST_WB : ST_IDLE;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Register addresses and ALU select stay put for the whole life of an instruction.
  always_comb begin
    instr_ready = 1'b0;
    rs          = '0;
    rt          = '0;
    rd          = '0;
    ALU_OP      = ALU_AND;
    Write_Reg   = 1'b0;
    Mem_Write   = 1'b0;
    wr_data_s   = WDS_IDLE;
    retire      = 1'b0;
    illegal     = 1'b0;
    if (state_reg == ST_IDLE) begin
      instr_ready = 1'b1;
    end else begin
      rs     = ir_reg.rs;
      rt     = ir_reg.rt;
      rd     = ir_reg.rd;
      ALU_OP = dec_alu_op;
    end
    case (state_reg)
      ST_DEC: illegal = dec_is_illegal;
      ST_MEM: begin
        Mem_Write = dec_is_sw;
        retire    = dec_is_sw;
      end
      ST_WB: begin
        Write_Reg = (ir_reg.rd != 5'd0);
        wr_data_s = dec_is_lw ? WDS_RAM : WDS_ALU;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FLAG_STICKY_EN
  logic [1:0] flag_in;
  logic [1:0] sticky_bits;
  assign flag_in = {OF, ZF};

  // Clear takes priority over a set landing on the same edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sticky
    logic flag_reg;
    always_ff @(posedge clk) begin
      if (Reset || clr_flags) flag_reg <= 1'b0;
      else if (state_reg == ST_EXE && flag_in[gi]) flag_reg <= 1'b1;
    end
    assign sticky_bits[gi] = flag_reg;
  end

  assign zf_sticky = sticky_bits[0];
  assign of_sticky = sticky_bits[1];
`else
  logic unused_flags;
  assign unused_flags = ^{ZF, OF, clr_flags};
  assign zf_sticky    = 1'b0;
  assign of_sticky    = 1'b0;
`endif

endmodule
